alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_fifo.sv | 67 ++++++
 rtl/alu_issue_unit.sv | 112 +++++++++++
 tb/tb_alu_issue_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode constants and the request record used by
// the ALU issue unit and its operation FIFO.
//   OP_W / DATA_W : control-code and operand widths
//   OP_*          : the five legal control codes (meaning defined by the ALU)
//   alu_req_t     : one queued operation {a, b, op}
//   is_legal_op   : 1 for codes 3'b000..3'b100, 0 for 3'b101..3'b111
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

    // Legal codes are a contiguous range starting at zero.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: synchronous FIFO of pending ALU operations.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data: write one entry; ignored when full
//   pop, pop_data  : pop_data is the head entry; pop removes it, ignored when empty
//   full, empty    : occupancy flags
//   count          : number of stored entries, 0..DEPTH
// No bypass: an entry written on an edge appears at the head only after it.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  alu_req_t                 push_data,
    input  logic                     pop,
    output alu_req_t                 pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    alu_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU requests, drives an external combinational ALU
// from a registered issue stage and captures its outputs into a result record.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready, in_a/b/op   : request handshake and payload
//   alu_a/alu_b/alu_control        : registered drive to the external ALU
//   alu_result/carry/zero          : combinational ALU outputs
//   out_valid/out_ready, out_*     : result handshake and registered record
//   fifo_count                     : current FIFO occupancy
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid keeps its payload stable until then,
// and ready never depends combinationally on valid.
// Pipeline: FIFO -> issue register -> result register; each stage may load
// on the same edge its contents move on, giving one result per cycle.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_a,
    input  logic [DATA_W-1:0]       in_b,
    input  logic [OP_W-1:0]         in_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_control,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_result,
    output logic                    out_carry,
    output logic                    out_zero,
    output logic [OP_W-1:0]         out_op,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    alu_req_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;
    logic     issue_valid;
    logic     issue_adv;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign issue_adv = issue_valid && (!out_valid || out_ready);
    assign pop       = !fifo_empty && (!issue_valid || issue_adv);

    alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_a, in_b, in_op}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue register: holds while the result stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
        end else if (pop) begin
            issue_valid <= 1'b1;
            alu_a       <= head.a;
            alu_b       <= head.b;
            alu_control <= head.op;
        end else if (issue_adv) begin
            issue_valid <= 1'b0;
        end
    end

    // Result register: illegal codes report a zeroed result with the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_op      <= '0;
            out_illegal <= 1'b0;
        end else if (issue_adv) begin
            out_valid <= 1'b1;
            out_op    <= alu_control;
            if (is_legal_op(alu_control)) begin
                out_result  <= alu_result;
                out_carry   <= alu_carry;
                out_zero    <= alu_zero;
                out_illegal <= 1'b0;
            end else begin
                out_result  <= '0;
                out_carry   <= 1'b0;
                out_zero    <= 1'b0;
                out_illegal <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: bench for alu_issue_unit with a behavioural ALU attached
// to the alu_* ports, a request driver, and a monitor that pops expected
// result records from exp_q whenever a result transfer is seen.
// Record layout: {illegal, op[2:0], zero, carry, result[3:0]}.
module tb_alu_issue_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_control;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic [2:0] out_op;
    logic       out_illegal;
    logic [2:0] fifo_count;

    int         errors = 0;
    int         checks = 0;
    logic [9:0] exp_q[$];
    bit         rand_ready = 1'b0;

    alu_issue_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_op      (out_op),
        .out_illegal (out_illegal),
        .fifo_count  (fifo_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- external ALU and reference model ----------------
    // Returns {carry, result}; unused codes give a nonzero junk value.
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        int sa;
        int sb;
        int s;
        logic [4:0] r;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: begin s = sa + sb; r = {(s > 15), 4'(s % 16)}; end
            3'd1: begin s = (sa - sb + 16) % 16; r = {(sa < sb), 4'(s)}; end
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_control);
        alu_zero = (alu_result == 4'd0);
    end

    function automatic logic [9:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [4:0] cr;
        if (op > 3'd4) begin
            return {1'b1, op, 6'b0};
        end
        cr = alu_fn(a, b, op);
        return {1'b0, op, (cr[3:0] == 4'd0), cr[4], cr[3:0]};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [9:0] rec;
        logic [9:0] prev_rec;
        logic [9:0] exp_rec;
        bit         hold_pending;
        hold_pending = 1'b0;
        prev_rec     = '0;
        forever begin
            @(negedge clk);
            rec = {out_illegal, out_op, out_zero, out_carry, out_result};
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("out_hold", {22'd0, out_valid, rec}, {22'd0, 1'b1, prev_rec});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h with no result expected at %0t",
                                 rec, $time);
                    end else begin
                        exp_rec = exp_q.pop_front();
                        check("result_record", {22'd0, rec}, {22'd0, exp_rec});
                    end
                end
                hold_pending = out_valid && !out_ready;
                prev_rec     = rec;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input int max_wait, output bit accepted);
        accepted = 1'b0;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        for (int i = 0; i < max_wait && !accepted; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_model(a, b, op));
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_must(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit acc;
        push_op(a, b, op, 40, acc);
        check("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("reset_alu_drive", {21'd0, alu_a, alu_b, alu_control}, 32'd0);
        check("reset_out_record",
              {22'd0, out_illegal, out_op, out_zero, out_carry, out_result}, 32'd0);

        // Single op latency: out_valid appears after the second edge
        out_ready = 1'b1;
        push_op(4'd3, 4'd1, 3'b000, 4, acc);
        check("single_accepted", {31'd0, acc}, 32'd1);
        check("single_valid_n", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("single_valid_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("single_valid_n2", {31'd0, out_valid}, 32'd1);
        wait_drain(10);

        // Back-pressure: DEPTH + 2 accepted, then drain one per cycle
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_must(4'(i + 5), 4'(i), 3'(i % 5));
        end
        push_op(4'd9, 4'd9, 3'b010, 4, acc);
        check("bp_seventh_rejected", {31'd0, acc}, 32'd0);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_fifo_count", {29'd0, fifo_count}, 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("bp_drain_valid", {31'd0, out_valid}, (k < 6) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        wait_drain(10);

        // Illegal op
        push_must(4'd12, 4'd10, 3'b110);
        wait_drain(10);

        // Push and pop on the same edge with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_must(4'(i), 4'(15 - i), 3'(i));
        end
        check("pp_count_before", {29'd0, fifo_count}, 32'd3);
        in_a = 4'd7; in_b = 4'd8; in_op = 3'b001;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pp_in_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back(ref_model(4'd7, 4'd8, 3'b001));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_count_after", {29'd0, fifo_count}, 32'd3);
        push_op(4'd2, 4'd2, 3'b001, 3, acc);
        check("pp_last_accepted", {31'd0, acc}, 32'd1);
        check("pp_count_full", {29'd0, fifo_count}, 32'd4);
        check("pp_in_ready_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        wait_drain(20);

        // Wrap-around stream under random out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_must(4'(i), 4'(i + 1), 3'($urandom_range(0, 7)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain(40);

        // Reset mid-flight, with requests offered during reset
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_must(4'(i + 1), 4'(i + 2), 3'b000);
        end
        check("mr_out_valid_before", {31'd0, out_valid}, 32'd1);
        check("mr_count_before", {29'd0, fifo_count}, 32'd3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 4'd5;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("mr_no_stale", {31'd0, out_valid}, 32'd0);

        // A fresh op after reset still flows correctly
        push_must(4'd15, 4'd1, 3'b000);
        wait_drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
